// File: rtl/vip_multi_bbox_detect.sv
// Multi-target bounding-box detector for a 1-bit/pixel stream: clusters set pixels into NUM_TGT slots.
// Optional area filter and per-slot pixel counts via `define VIP_MTD_AREA_FILTER_EN.
module vip_multi_bbox_detect #(
  parameter int NUM_TGT   = 4,
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int XW        = 11,
  parameter int YW        = 10,
  parameter int CNT_W     = 20
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 per_frame_vsync,
  input  logic                                 per_frame_href,
  input  logic                                 per_frame_clken,
  input  logic                                 per_img_bit,
  input  logic [YW-1:0]                        min_dist,
  input  logic [CNT_W-1:0]                     min_pixels,
  output logic [NUM_TGT*(2*XW+2*YW)-1:0]       target_pos_out,
  output logic [NUM_TGT-1:0]                   target_valid,
  output logic [NUM_TGT*CNT_W-1:0]             target_pix_cnt,
  output logic                                 target_overflow,
  output logic                                 frame_done
);

  localparam int BW = 2*XW + 2*YW;
  localparam int NW = ((XW > YW) ? XW : YW) + 1;
  localparam logic [XW-1:0] XMAX = XW'(IMG_HDISP - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_VDISP - 1);
  localparam logic [NW-1:0] XLIM = NW'(IMG_HDISP - 1);
  localparam logic [NW-1:0] YLIM = NW'(IMG_VDISP - 1);
  localparam logic [NUM_TGT-1:0] ONE = NUM_TGT'(1);

  // Window test on one axis, one bit wider than the coordinate so margins never wrap.
  function automatic logic in_win(input logic [NW-1:0] p, input logic [NW-1:0] lo_b,
                                  input logic [NW-1:0] hi_b, input logic [NW-1:0] d,
                                  input logic [NW-1:0] lim);
    logic [NW-1:0] lo;
    logic [NW-1:0] hi;
    lo = (lo_b >= d) ? (lo_b - d) : '0;
    hi = hi_b + d;
    if (hi > lim) hi = lim;
    return (p >= lo) && (p <= hi);
  endfunction

  logic          vsync_q, href_q, frame_open_q;
  logic          vs_rise, vs_fall;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          pix;

  logic [NUM_TGT-1:0] vld_q;
  logic [XW-1:0]      xmin_q [NUM_TGT];
  logic [XW-1:0]      xmax_q [NUM_TGT];
  logic [YW-1:0]      ymin_q [NUM_TGT];
  logic [YW-1:0]      ymax_q [NUM_TGT];
  logic               ovf_q;

  logic               s1_vld_q;
  logic [NUM_TGT-1:0] s1_hit_q;
  logic [XW-1:0]      s1_x_q;
  logic [YW-1:0]      s1_y_q;
  logic [NUM_TGT-1:0] fwd_oh_q;

  logic [NUM_TGT-1:0] hit_s1_d, hit_s2_d, hit_eff_d, free_d, wr_oh_d, valid_d;
  logic               ext_d, wr_en_d, drop_d;

  logic [NUM_TGT*BW-1:0] pos_q;
  logic [NUM_TGT-1:0]    valid_q;
  logic                  ovf_out_q, done_q;

  assign vs_rise = per_frame_vsync && !vsync_q;
  assign vs_fall = !per_frame_vsync && vsync_q;
  assign pix     = per_frame_vsync && per_frame_href && per_frame_clken && per_img_bit;

  // vsync_q resets high so a vsync already high out of reset is not mistaken for a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      frame_open_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (vs_rise)      frame_open_q <= 1'b1;
      else if (vs_fall) frame_open_q <= 1'b0;
      if (!per_frame_href)                    x_q <= '0;
      else if (per_frame_clken && x_q != XMAX) x_q <= x_q + 1'b1;
      if (!per_frame_vsync)                                  y_q <= '0;
      else if (href_q && !per_frame_href && y_q != YMAX)     y_q <= y_q + 1'b1;
    end
  end

  always_comb begin
    hit_s1_d = '0;
    hit_s2_d = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      hit_s1_d[i] = vld_q[i] &&
        in_win(NW'(x_q), NW'(xmin_q[i]), NW'(xmax_q[i]), NW'(min_dist), XLIM) &&
        in_win(NW'(y_q), NW'(ymin_q[i]), NW'(ymax_q[i]), NW'(min_dist), YLIM);
      hit_s2_d[i] = vld_q[i] &&
        in_win(NW'(s1_x_q), NW'(xmin_q[i]), NW'(xmax_q[i]), NW'(min_dist), XLIM) &&
        in_win(NW'(s1_y_q), NW'(ymin_q[i]), NW'(ymax_q[i]), NW'(min_dist), YLIM);
    end
    // Stage-1 hits predate last cycle's write; recheck only that slot when nothing else hit.
    hit_eff_d = (s1_hit_q != '0) ? s1_hit_q : (hit_s2_d & fwd_oh_q);
    ext_d     = |hit_eff_d;
    free_d    = ~vld_q;
    if (ext_d) wr_oh_d = hit_eff_d & (~hit_eff_d + ONE);
    else       wr_oh_d = free_d & (~free_d + ONE);
    wr_en_d = s1_vld_q && !vs_rise && (ext_d || (free_d != '0));
    drop_d  = s1_vld_q && !vs_rise && !ext_d && (free_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || vs_rise) begin
      s1_vld_q <= 1'b0;
      s1_hit_q <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      fwd_oh_q <= '0;
    end else begin
      s1_vld_q <= pix;
      s1_hit_q <= pix ? hit_s1_d : '0;
      s1_x_q   <= x_q;
      s1_y_q   <= y_q;
      fwd_oh_q <= wr_en_d ? wr_oh_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || vs_rise) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_TGT; i++) begin
        xmin_q[i] <= '0;
        xmax_q[i] <= '0;
        ymin_q[i] <= '0;
        ymax_q[i] <= '0;
      end
    end else begin
      if (drop_d) ovf_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_TGT; i++) begin
        if (wr_en_d && wr_oh_d[i]) begin
          if (ext_d) begin
            if (s1_x_q < xmin_q[i]) xmin_q[i] <= s1_x_q;
            if (s1_x_q > xmax_q[i]) xmax_q[i] <= s1_x_q;
            if (s1_y_q < ymin_q[i]) ymin_q[i] <= s1_y_q;
            if (s1_y_q > ymax_q[i]) ymax_q[i] <= s1_y_q;
          end else begin
            vld_q[i]  <= 1'b1;
            xmin_q[i] <= s1_x_q;
            xmax_q[i] <= s1_x_q;
            ymin_q[i] <= s1_y_q;
            ymax_q[i] <= s1_y_q;
          end
        end
      end
    end
  end

`ifdef VIP_MTD_AREA_FILTER_EN
  logic [CNT_W-1:0]       cnt_q [NUM_TGT];
  logic [NUM_TGT*CNT_W-1:0] cnt_out_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (!rst_n || vs_rise)                         cnt_q[i] <= '0;
      else if (wr_en_d && wr_oh_d[i] && !ext_d)      cnt_q[i] <= CNT_W'(1);
      else if (wr_en_d && wr_oh_d[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    valid_d = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++)
      valid_d[i] = vld_q[i] && (cnt_q[i] >= min_pixels);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_out_q <= '0;
    else if (vs_fall && frame_open_q)
      for (int unsigned i = 0; i < NUM_TGT; i++)
        cnt_out_q[i*CNT_W +: CNT_W] <= vld_q[i] ? cnt_q[i] : '0;
  end

  assign target_pix_cnt = cnt_out_q;
`else
  logic unused_min_pixels;
  assign unused_min_pixels = ^min_pixels;
  assign valid_d           = vld_q;
  assign target_pix_cnt    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q     <= '0;
      valid_q   <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= vs_fall && frame_open_q;
      if (vs_fall && frame_open_q) begin
        valid_q   <= valid_d;
        ovf_out_q <= ovf_q;
        for (int unsigned i = 0; i < NUM_TGT; i++)
          pos_q[i*BW +: BW] <= vld_q[i] ? {ymax_q[i], xmax_q[i], ymin_q[i], xmin_q[i]} : '0;
      end
    end
  end

  assign target_pos_out  = pos_q;
  assign target_valid    = valid_q;
  assign target_overflow = ovf_out_q;
  assign frame_done      = done_q;

endmodule
